// File: rtl/alu_control_mdu.sv
// ALU control decode for the MIPS EX stage plus an iterative multiply/divide unit with HI/LO.
// Optional feature macro ALU_CTRL_FAST_MUL_EN: single-edge combinational multiply, divide unchanged.
module alu_control_mdu #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             stall,
  output logic             busy
);

  localparam int unsigned CW      = $clog2(WIDTH);
  localparam logic [5:0]  F_MULT  = 6'b011000;
  localparam logic [5:0]  F_MULTU = 6'b011001;
  localparam logic [5:0]  F_DIV   = 6'b011010;
  localparam logic [5:0]  F_DIVU  = 6'b011011;
  localparam logic [5:0]  F_MFHI  = 6'b010000;
  localparam logic [5:0]  F_MTHI  = 6'b010001;
  localparam logic [5:0]  F_MFLO  = 6'b010010;
  localparam logic [5:0]  F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q;
  logic                 q_neg_q;
  logic                 r_neg_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 rtype_s;
  logic                 mdu_fn_s;
  logic                 signed_op_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic                 start_mul_s;
  logic                 start_div_s;
  logic                 mthi_we_s;
  logic                 mtlo_we_s;
  logic [WIDTH-1:0]     a_abs_s;
  logic [WIDTH-1:0]     b_abs_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [WIDTH-1:0]     quot_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;
  logic [2*WIDTH-1:0]   prod_fix_s;

  // ALU control decode from ALUOp and funct
  always_comb begin
    ALUControl = 4'b0000;
    case (ALUOp)
      2'b00: ALUControl = 4'b0010;
      2'b01: ALUControl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: ALUControl = 4'b0010;
          6'b100010, 6'b100011: ALUControl = 4'b0110;
          6'b100100: ALUControl = 4'b0000;
          6'b100101: ALUControl = 4'b0001;
          6'b100110: ALUControl = 4'b0011;
          6'b100111: ALUControl = 4'b1100;
          6'b101010: ALUControl = 4'b0111;
          6'b101011: ALUControl = 4'b1000;
          6'b000000: ALUControl = 4'b1001;
          6'b000010: ALUControl = 4'b1010;
          6'b000011: ALUControl = 4'b1011;
          default:   ALUControl = 4'b0000;
        endcase
      end
      default: ALUControl = 4'b0000;
    endcase
  end

  assign rtype_s  = (ALUOp == 2'b10);
  assign mdu_fn_s = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) ||
                    (funct == F_DIVU) || (funct == F_MFHI) || (funct == F_MFLO) ||
                    (funct == F_MTHI) || (funct == F_MTLO);
  assign busy     = (state_q != S_IDLE);
  assign stall    = valid & rtype_s & busy & mdu_fn_s;

  assign start_mul_s = valid & rtype_s & ~busy & ((funct == F_MULT) || (funct == F_MULTU));
  assign start_div_s = valid & rtype_s & ~busy & ((funct == F_DIV) || (funct == F_DIVU));
  assign mthi_we_s   = valid & rtype_s & ~busy & (funct == F_MTHI);
  assign mtlo_we_s   = valid & rtype_s & ~busy & (funct == F_MTLO);

  assign signed_op_s = (funct == F_MULT) || (funct == F_DIV);
  assign a_neg_s     = signed_op_s & rs_data[WIDTH-1];
  assign b_neg_s     = signed_op_s & rt_data[WIDTH-1];
  assign a_abs_s     = a_neg_s ? -rs_data : rs_data;
  assign b_abs_s     = b_neg_s ? -rt_data : rt_data;

  // Restoring divide step: work_q holds {remainder, remaining dividend / quotient bits}
  assign div_ge_s   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} >= {1'b0, opnd_q};
  assign div_diff_s = {work_q[2*WIDTH-2:WIDTH], work_q[WIDTH-1]} - opnd_q;
  assign div_next_s = div_ge_s ? {div_diff_s, work_q[WIDTH-2:0], 1'b1}
                               : {work_q[2*WIDTH-2:0], 1'b0};

`ifdef ALU_CTRL_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] fast_prod_s;

  assign ext_a_s     = signed_op_s ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data} : {{WIDTH{1'b0}}, rs_data};
  assign ext_b_s     = signed_op_s ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data} : {{WIDTH{1'b0}}, rt_data};
  assign fast_prod_s = ext_a_s * ext_b_s;
`else
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;

  assign mul_sum_s  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, work_q[WIDTH-1:1]};
`endif

  // Sign correction of the unsigned magnitude results
  always_comb begin
    if (q_neg_q) begin
      quot_fix_s = -work_q[WIDTH-1:0];
      prod_fix_s = -work_q;
    end else begin
      quot_fix_s = work_q[WIDTH-1:0];
      prod_fix_s = work_q;
    end
    if (r_neg_q) begin
      rem_fix_s = -work_q[2*WIDTH-1:WIDTH];
    end else begin
      rem_fix_s = work_q[2*WIDTH-1:WIDTH];
    end
  end

  // HI/LO read port for mfhi/mflo
  always_comb begin
    if (rtype_s && (funct == F_MFHI)) begin
      hilo_rdata = hi_q;
    end else if (rtype_s && (funct == F_MFLO)) begin
      hilo_rdata = lo_q;
    end else begin
      hilo_rdata = '0;
    end
  end

  // MDU sequencer, operand latches and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= HILO_RESET;
      lo_q     <= HILO_RESET;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (start_mul_s) begin
`ifdef ALU_CTRL_FAST_MUL_EN
            {hi_q, lo_q} <= fast_prod_s;
`else
            state_q  <= S_MUL;
            work_q   <= {{WIDTH{1'b0}}, b_abs_s};
            opnd_q   <= a_abs_s;
            is_div_q <= 1'b0;
            q_neg_q  <= a_neg_s ^ b_neg_s;
            r_neg_q  <= 1'b0;
`endif
          end else if (start_div_s) begin
            state_q  <= S_DIV;
            work_q   <= {{WIDTH{1'b0}}, a_abs_s};
            opnd_q   <= b_abs_s;
            is_div_q <= 1'b1;
            // A zero divisor leaves the all-ones quotient uncorrected
            q_neg_q  <= (a_neg_s ^ b_neg_s) & (rt_data != '0);
            r_neg_q  <= a_neg_s;
          end else if (mthi_we_s) begin
            hi_q <= rs_data;
          end else if (mtlo_we_s) begin
            lo_q <= rs_data;
          end
        end
`ifndef ALU_CTRL_FAST_MUL_EN
        S_MUL: begin
          work_q <= mul_next_s;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
`endif
        S_DIV: begin
          work_q <= div_next_s;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
          if (is_div_q) begin
            lo_q <= quot_fix_s;
            hi_q <= rem_fix_s;
          end else begin
            {hi_q, lo_q} <= prod_fix_s;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: decode table, directed MDU cases, reset abort,
// mthi/mtlo handling and randomized operations against an arithmetic reference model.
module tb_alu_control_mdu;

  localparam int unsigned W       = 32;
  localparam logic [31:0] HRST    = 32'hA5A5_0F0F;
  localparam logic [5:0]  F_MULT  = 6'b011000;
  localparam logic [5:0]  F_MULTU = 6'b011001;
  localparam logic [5:0]  F_DIV   = 6'b011010;
  localparam logic [5:0]  F_DIVU  = 6'b011011;
  localparam logic [5:0]  F_MFHI  = 6'b010000;
  localparam logic [5:0]  F_MTHI  = 6'b010001;
  localparam logic [5:0]  F_MFLO  = 6'b010010;
  localparam logic [5:0]  F_MTLO  = 6'b010011;
  localparam logic [5:0]  F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  ALUControl;
  logic [31:0] hilo_rdata;
  logic        stall;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_control_mdu #(.WIDTH(W), .HILO_RESET(HRST)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .ALUControl(ALUControl),
    .hilo_rdata(hilo_rdata), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_vec_t;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_vec_t;

  dec_vec_t dec_tbl[21];
  mdu_vec_t mdu_tbl[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic present(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
    valid   = v;
    ALUOp   = op;
    funct   = fn;
    rs_data = a;
    rt_data = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on 64-bit values
  task automatic ref_mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (fn == F_MULT) begin
      p = 64'(sa * sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (fn == F_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (fn == F_DIV) begin
      lo = 32'(sa / sb);
      hi = 32'(sa % sb);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  function automatic int exp_lat(input logic [5:0] fn);
`ifdef ALU_CTRL_FAST_MUL_EN
    return ((fn == F_DIV) || (fn == F_DIVU)) ? 33 : 0;
`else
    return 33;
`endif
  endfunction

  // Issue one MDU op, follow it with mflo (counting stall cycles) then mfhi
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat);
    present(1'b1, 2'b10, fn, a, b);
    @(negedge clk);
    check("idle_before_issue", {31'd0, busy}, 32'd0);
    next_cycle();
    present(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    lat = 0;
    @(negedge clk);
    while (stall && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    lo = hilo_rdata;
    next_cycle();
    present(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    hi = hilo_rdata;
    next_cycle();
    present(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic [5:0]  rfn;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;

    dec_tbl[0]  = '{2'b00, 6'b101010, 4'b0010};
    dec_tbl[1]  = '{2'b01, 6'b100000, 4'b0110};
    dec_tbl[2]  = '{2'b11, 6'b100101, 4'b0000};
    dec_tbl[3]  = '{2'b10, 6'b100000, 4'b0010};
    dec_tbl[4]  = '{2'b10, 6'b100001, 4'b0010};
    dec_tbl[5]  = '{2'b10, 6'b100010, 4'b0110};
    dec_tbl[6]  = '{2'b10, 6'b100011, 4'b0110};
    dec_tbl[7]  = '{2'b10, 6'b100100, 4'b0000};
    dec_tbl[8]  = '{2'b10, 6'b100101, 4'b0001};
    dec_tbl[9]  = '{2'b10, 6'b100110, 4'b0011};
    dec_tbl[10] = '{2'b10, 6'b100111, 4'b1100};
    dec_tbl[11] = '{2'b10, 6'b101010, 4'b0111};
    dec_tbl[12] = '{2'b10, 6'b101011, 4'b1000};
    dec_tbl[13] = '{2'b10, 6'b000000, 4'b1001};
    dec_tbl[14] = '{2'b10, 6'b000010, 4'b1010};
    dec_tbl[15] = '{2'b10, 6'b000011, 4'b1011};
    dec_tbl[16] = '{2'b10, 6'b011000, 4'b0000};
    dec_tbl[17] = '{2'b10, 6'b011011, 4'b0000};
    dec_tbl[18] = '{2'b10, 6'b010000, 4'b0000};
    dec_tbl[19] = '{2'b10, 6'b010011, 4'b0000};
    dec_tbl[20] = '{2'b10, 6'b111111, 4'b0000};

    mdu_tbl[0] = '{F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    mdu_tbl[1] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    mdu_tbl[2] = '{F_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    mdu_tbl[3] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    mdu_tbl[4] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    present(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    present(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    #1;
    check("rst_hi", hilo_rdata, HRST);
    check("rst_stall", {31'd0, stall}, 32'd0);
    present(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    #1;
    check("rst_lo", hilo_rdata, HRST);
    present(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 21; i++) begin
      present(1'b0, dec_tbl[i].op, dec_tbl[i].fn, 32'd0, 32'd0);
      #1;
      check($sformatf("decode_%0d", i), {28'd0, ALUControl}, {28'd0, dec_tbl[i].exp});
    end
    next_cycle();

    for (int i = 0; i < 5; i++) begin
      run_op(mdu_tbl[i].fn, mdu_tbl[i].a, mdu_tbl[i].b, hi, lo, lat);
      check($sformatf("dir_lat_%0d", i), lat, exp_lat(mdu_tbl[i].fn));
      check($sformatf("dir_lo_%0d", i), lo, mdu_tbl[i].lo);
      check($sformatf("dir_hi_%0d", i), hi, mdu_tbl[i].hi);
    end

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: rfn = F_MULT;
        1: rfn = F_MULTU;
        2: rfn = F_DIV;
        default: rfn = F_DIVU;
      endcase
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      ref_mdu(rfn, ra, rb, ehi, elo);
      run_op(rfn, ra, rb, hi, lo, lat);
      check($sformatf("rnd_lat_%0d", i), lat, exp_lat(rfn));
      check($sformatf("rnd_lo_%0d", i), lo, elo);
      check($sformatf("rnd_hi_%0d", i), hi, ehi);
    end

    // Reset in the middle of a divide aborts it and restores HI/LO
    present(1'b1, 2'b10, F_DIV, 32'd100, 32'd7);
    next_cycle();
    present(1'b1, 2'b10, F_ADD, 32'd1, 32'd2);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("add_busy_stall", {31'd0, stall}, 32'd0);
        check("add_busy_ctrl", {28'd0, ALUControl}, 32'd2);
        check("div_busy", {31'd0, busy}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    present(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    #1;
    check("abort_hi", hilo_rdata, HRST);
    reset = 1'b0;
    present(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    #1;
    check("abort_lo", hilo_rdata, HRST);
    next_cycle();
    next_cycle();
    check("abort_idle", {31'd0, busy}, 32'd0);

    present(1'b1, 2'b10, F_MTHI, 32'h1234_5678, 32'd0);
    next_cycle();
    present(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi", hilo_rdata, 32'h1234_5678);
    next_cycle();
    present(1'b0, 2'b10, F_MTLO, 32'hCAFE_F00D, 32'd0);
    next_cycle();
    present(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    check("mtlo_invalid", hilo_rdata, HRST);
    next_cycle();
    present(1'b1, 2'b10, F_MTLO, 32'h0BAD_F00D, 32'd0);
    next_cycle();
    present(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    check("mtlo", hilo_rdata, 32'h0BAD_F00D);
    next_cycle();

    // mthi presented while a multiply runs must wait for the unit to go idle
    present(1'b1, 2'b10, F_MULTU, 32'd3, 32'd5);
    next_cycle();
    present(1'b1, 2'b10, F_MTHI, 32'hDEAD_BEEF, 32'd0);
    lat = 0;
    @(negedge clk);
    while (stall && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check("mthi_busy_lat", lat, exp_lat(F_MULTU));
    funct = F_MFHI;
    #1;
    check("mthi_pending_hi", hilo_rdata, 32'd0);
    funct = F_MTHI;
    next_cycle();
    present(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_after_busy", hilo_rdata, 32'hDEAD_BEEF);
    next_cycle();
    present(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    check("mthi_lo_kept", hilo_rdata, 32'd15);
    next_cycle();

`ifdef ALU_CTRL_FAST_MUL_EN
    present(1'b1, 2'b10, F_MULTU, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    check("fast_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    present(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("fast_busy", {31'd0, busy}, 32'd0);
    check("fast_hi", hilo_rdata, 32'd1);
    next_cycle();
    present(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    check("fast_lo", hilo_rdata, 32'hFFFF_FFFE);
    next_cycle();
`endif

    present(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
